// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl
//   Sequences each core data-port transaction onto the data RAM or the UART TX
//   register and returns a single-cycle data_ready (qualified by bus_error).
//   Owns address decode, RAM write-enable gating, the one-cycle RAM read
//   latency, and the UART completion wait with timeout.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   data_read_valid/data_write_valid  core request strobes (sampled in IDLE)
//   data_addr/data_write/data_write_byte  core address, write data, byte enables
//   data_read, data_ready, bus_error  registered response to the core
//   ram_addr/ram_we/ram_byte_we/ram_data_in  data RAM request (registered)
//   ram_data_out                      data RAM read data, one cycle after ram_addr
//   uart_tx_data/uart_tx_start        UART byte and one-cycle start strobe
//   uart_xfer_done                    UART finished the current byte
module data_bus_ctrl #(
  parameter int          RAM_ADDR_BITS = 14,
  parameter logic [31:0] UART_ADDR     = 32'h0001_0000,
  parameter int          UART_TIMEOUT  = 20000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     data_read_valid,
  input  logic                     data_write_valid,
  input  logic [31:0]              data_addr,
  input  logic [31:0]              data_write,
  input  logic [3:0]               data_write_byte,
  output logic [31:0]              data_read,
  output logic                     data_ready,
  output logic                     bus_error,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic                     ram_we,
  output logic [3:0]               ram_byte_we,
  output logic [31:0]              ram_data_in,
  input  logic [31:0]              ram_data_out,
  output logic [7:0]               uart_tx_data,
  output logic                     uart_tx_start,
  input  logic                     uart_xfer_done
);

  localparam int TW = $clog2(UART_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(UART_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RAM_ACC, RAM_WAIT, UART_TX, UART_WAIT, DONE
  } state_t;

  state_t        state_q;
  logic          wr_q;     // latched direction of the accepted request
  logic [TW-1:0] timer_q;

  logic req, ram_hit, uart_hit, dec_err;

  assign req      = data_read_valid | data_write_valid;
  // RAM occupies the low 2**RAM_ADDR_BITS bytes; UART is a single exact address.
  assign ram_hit  = (data_addr >> RAM_ADDR_BITS) == 32'd0;
  assign uart_hit = data_addr == UART_ADDR;
  // Ambiguous request, UART read, or nothing mapped -> fail without touching a device.
  assign dec_err  = (data_read_valid & data_write_valid) |
                    ~(ram_hit | (uart_hit & data_write_valid));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wr_q          <= 1'b0;
      timer_q       <= '0;
      data_read     <= '0;
      data_ready    <= 1'b0;
      bus_error     <= 1'b0;
      ram_addr      <= '0;
      ram_we        <= 1'b0;
      ram_byte_we   <= '0;
      ram_data_in   <= '0;
      uart_tx_data  <= '0;
      uart_tx_start <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            wr_q <= data_write_valid;
            if (dec_err) begin
              data_read  <= '0;
              data_ready <= 1'b1;
              bus_error  <= 1'b1;
              state_q    <= DONE;
            end else if (ram_hit) begin
              // RAM request registers are loaded here so they are live in RAM_ACC.
              ram_addr    <= data_addr[RAM_ADDR_BITS-1:0];
              ram_data_in <= data_write;
              ram_byte_we <= data_write_valid ? data_write_byte : 4'b0000;
              ram_we      <= data_write_valid & (|data_write_byte);
              state_q     <= RAM_ACC;
            end else begin
              uart_tx_data  <= data_write[7:0];
              uart_tx_start <= 1'b1;
              state_q       <= UART_TX;
            end
          end
        end
        RAM_ACC: begin
          ram_we      <= 1'b0;
          ram_byte_we <= '0;
          if (wr_q) begin
            data_ready <= 1'b1;
            state_q    <= DONE;
          end else begin
            state_q <= RAM_WAIT;
          end
        end
        RAM_WAIT: begin
          data_read  <= ram_data_out;
          data_ready <= 1'b1;
          state_q    <= DONE;
        end
        UART_TX: begin
          uart_tx_start <= 1'b0;
          timer_q       <= '0;
          state_q       <= UART_WAIT;
        end
        UART_WAIT: begin
          timer_q <= timer_q + 1'b1;
          // Completion takes priority over a timeout landing in the same cycle.
          if (uart_xfer_done) begin
            data_ready <= 1'b1;
            state_q    <= DONE;
          end else if (timer_q == TMO_LAST) begin
            data_ready <= 1'b1;
            bus_error  <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          data_ready <= 1'b0;
          bus_error  <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Testbench for data_bus_ctrl: table of directed transactions with hand-derived
// expectations, random transactions against a transaction-level model, and a
// hand-written reset-abort sequence.
module tb_data_bus_ctrl;

  localparam int          RAB   = 14;
  localparam logic [31:0] UADDR = 32'h0001_0000;
  localparam int          T     = 100;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           data_read_valid = 1'b0, data_write_valid = 1'b0;
  logic [31:0]    data_addr = '0, data_write = '0;
  logic [3:0]     data_write_byte = '0;
  logic [31:0]    data_read;
  logic           data_ready, bus_error;
  logic [RAB-1:0] ram_addr;
  logic           ram_we;
  logic [3:0]     ram_byte_we;
  logic [31:0]    ram_data_in;
  logic [31:0]    ram_data_out = '0;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_start;
  logic           uart_xfer_done = 1'b0;

  data_bus_ctrl #(.RAM_ADDR_BITS(RAB), .UART_ADDR(UADDR), .UART_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .data_read_valid(data_read_valid), .data_write_valid(data_write_valid),
    .data_addr(data_addr), .data_write(data_write), .data_write_byte(data_write_byte),
    .data_read(data_read), .data_ready(data_ready), .bus_error(bus_error),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_byte_we(ram_byte_we),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
    .uart_xfer_done(uart_xfer_done)
  );

  always #5 clk = ~clk;

  // Simple synchronous RAM device: byte-lane writes, one-cycle read latency.
  bit [31:0] dev[1 << (RAB-2)];
  always @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_byte_we[b]) dev[ram_addr[RAB-1:2]][8*b +: 8] <= ram_data_in[8*b +: 8];
    ram_data_out <= dev[ram_addr[RAB-1:2]];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: memory image by word, last read data.
  bit [31:0]   mem_ref[1 << (RAB-2)];
  logic [31:0] dr_ref = '0;

  task automatic model(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input int d,
                       output int lat, output bit err, output logic [31:0] dat,
                       output int we_n, output int tx_n);
    bit ram, uart;
    int idx;
    ram  = addr < (32'd1 << RAB);
    uart = addr == UADDR;
    idx  = int'(addr[RAB-1:0]) / 4;
    lat = 0; err = 0; we_n = 0; tx_n = 0;
    if ((rd && wr) || !(ram || (uart && wr))) begin
      lat = 1; err = 1; dr_ref = '0;
    end else if (ram && wr) begin
      lat = 2; we_n = (be != 0) ? 1 : 0;
      for (int b = 0; b < 4; b++) if (be[b]) mem_ref[idx][8*b +: 8] = wd[8*b +: 8];
    end else if (ram) begin
      lat = 3; dr_ref = mem_ref[idx];
    end else begin
      tx_n = 1;
      // UART waits cover cycles 2..T+1 after acceptance; done there wins.
      if (d >= 2 && d <= T + 1) lat = d + 1;
      else begin lat = T + 2; err = 1; end
    end
    dat = dr_ref;
  endtask

  // Drive one request; cycle 1 is the cycle after the accept edge.
  // uart_xfer_done is high during cycle d only (d=0: never).
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input int d,
                         output int lat, output bit err, output logic [31:0] dat,
                         output int we_n, output int we_cyc, output int tx_n,
                         output logic [7:0] txd, output bit pulse_ok);
    int cyc = 0;
    lat = -1; err = 0; dat = 'x; we_n = 0; we_cyc = 0; tx_n = 0; txd = '0; pulse_ok = 0;
    @(negedge clk);
    data_read_valid = rd; data_write_valid = wr;
    data_addr = addr; data_write = wd; data_write_byte = be;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (ram_we) begin we_n++; we_cyc = cyc; end
      if (uart_tx_start) begin tx_n++; txd = uart_tx_data; end
      if (data_ready) begin
        lat = cyc; err = bus_error; dat = data_read;
        break;
      end
      uart_xfer_done = (cyc == d);
    end
    uart_xfer_done = 1'b0;
    data_read_valid = 1'b0; data_write_valid = 1'b0;
    @(posedge clk); #1;
    pulse_ok = !data_ready;
  endtask

  typedef struct {
    bit rd; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int d;
    int lat; bit err; logic [31:0] data;
  } vec_t;

  task automatic apply(input vec_t v, input bit tbl, input string tag);
    int el, ewe, etx, lat, wen, wec, txn;
    bit eerr, err, pok;
    logic [31:0] edat, dat;
    logic [7:0] txd, wlo;
    model(v.rd, v.wr, v.addr, v.wdata, v.be, v.d, el, eerr, edat, ewe, etx);
    run_txn(v.rd, v.wr, v.addr, v.wdata, v.be, v.d, lat, err, dat, wen, wec, txn, txd, pok);
    wlo = v.wdata[7:0];
    chk({tag, ".lat"}, 64'(lat), 64'(el));
    chk({tag, ".err"}, 64'(err), 64'(eerr));
    chk({tag, ".data"}, 64'(dat), 64'(edat));
    chk({tag, ".we_cnt"}, 64'(wen), 64'(ewe));
    if (ewe != 0) chk({tag, ".we_cyc"}, 64'(wec), 64'd1);
    chk({tag, ".tx_cnt"}, 64'(txn), 64'(etx));
    if (etx != 0) chk({tag, ".tx_data"}, 64'(txd), 64'(wlo));
    chk({tag, ".pulse"}, 64'(pok), 64'd1);
    if (tbl) begin
      chk({tag, ".tlat"}, 64'(lat), 64'(v.lat));
      chk({tag, ".terr"}, 64'(err), 64'(v.err));
      chk({tag, ".tdata"}, 64'(dat), 64'(v.data));
    end
  endtask

  vec_t tv[21];

  initial begin
    vec_t v;
    int k, cnt;
    tv = '{
      //  rd wr addr          wdata          be      d    lat  err data
      '{0, 1, 32'h0000_0100, 32'hA5A5_1234, 4'hF,   0,   2,   0, 32'h0},
      '{1, 0, 32'h0000_0100, 32'h0,         4'h0,   0,   3,   0, 32'hA5A5_1234},
      '{0, 1, 32'h0000_0104, 32'hFFFF_FFFF, 4'hF,   0,   2,   0, 32'hA5A5_1234},
      '{0, 1, 32'h0000_0104, 32'h0000_5600, 4'h2,   0,   2,   0, 32'hA5A5_1234},
      '{1, 0, 32'h0000_0104, 32'h0,         4'h0,   0,   3,   0, 32'hFFFF_56FF},
      '{0, 1, 32'h0000_0104, 32'h1234_5678, 4'h0,   0,   2,   0, 32'hFFFF_56FF},
      '{1, 0, 32'h0000_0104, 32'h0,         4'h0,   0,   3,   0, 32'hFFFF_56FF},
      '{1, 0, 32'h0000_0107, 32'h0,         4'h0,   0,   3,   0, 32'hFFFF_56FF},
      '{0, 1, UADDR,         32'h0000_0041, 4'hF,  50,  51,   0, 32'hFFFF_56FF},
      '{0, 1, UADDR,         32'h0000_0042, 4'hF,   0, 102,   1, 32'hFFFF_56FF},
      '{0, 1, UADDR,         32'h0000_0043, 4'hF, 101, 102,   0, 32'hFFFF_56FF},
      '{0, 1, UADDR,         32'h0000_0044, 4'hF, 102, 102,   1, 32'hFFFF_56FF},
      '{0, 1, UADDR,         32'h0000_0045, 4'hF,   1, 102,   1, 32'hFFFF_56FF},
      '{0, 1, UADDR,         32'h0000_00C6, 4'hF,   2,   3,   0, 32'hFFFF_56FF},
      '{1, 0, 32'h0010_0000, 32'h0,         4'h0,   0,   1,   1, 32'h0},
      '{1, 0, 32'h0000_0104, 32'h0,         4'h0,   0,   3,   0, 32'hFFFF_56FF},
      '{1, 0, UADDR,         32'h0,         4'h0,   0,   1,   1, 32'h0},
      '{1, 1, 32'h0000_0100, 32'h1111_1111, 4'hF,   0,   1,   1, 32'h0},
      '{0, 1, 32'h0000_4000, 32'h2222_2222, 4'hF,   0,   1,   1, 32'h0},
      '{0, 1, 32'h0000_3FFC, 32'hDEAD_BEEF, 4'hF,   0,   2,   0, 32'h0},
      '{1, 0, 32'h0000_3FFC, 32'h0,         4'h0,   0,   3,   0, 32'hDEAD_BEEF}
    };

    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in.ctl", {data_ready, bus_error, ram_we, uart_tx_start, ram_byte_we,
                       uart_tx_data, ram_addr}, '0);
    chk("rst_in.data", {data_read, ram_data_in}, '0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out.ctl", {data_ready, bus_error, ram_we, uart_tx_start}, '0);

    for (int i = 0; i < 21; i++) apply(tv[i], 1'b1, $sformatf("tbl%0d", i));

    // Reset pulsed during UART_WAIT aborts the transaction silently.
    @(negedge clk);
    data_write_valid = 1'b1; data_addr = UADDR; data_write = 32'h55; data_write_byte = 4'hF;
    repeat (12) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort.ctl", {data_ready, bus_error, ram_we, uart_tx_start, ram_byte_we,
                      uart_tx_data, ram_addr}, '0);
    chk("abort.data", {data_read, ram_data_in}, '0);
    data_write_valid = 1'b0;
    dr_ref = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); uart_xfer_done = 1'b1;
    @(negedge clk); uart_xfer_done = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (data_ready || uart_tx_start || ram_we) cnt++;
    end
    chk("abort.quiet", 64'(cnt), 64'd0);
    v = '{1, 0, 32'h0000_0100, 32'h0, 4'h0, 0, 3, 0, 32'hA5A5_1234};
    apply(v, 1'b1, "abort.rd");

    // Random transactions against the model.
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      v = '{0, 0, 32'h0, $urandom, 4'($urandom_range(0, 15)), 0, 0, 0, 32'h0};
      if (k <= 3) begin
        v.wr = 1; v.addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      end else if (k <= 6) begin
        v.rd = 1; v.addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      end else if (k <= 8) begin
        v.wr = 1; v.addr = UADDR; v.d = $urandom_range(0, 105);
      end else begin
        case ($urandom_range(0, 3))
          0: begin v.rd = 1; v.addr = 32'h0010_0000 | 32'($urandom_range(0, 255)); end
          1: begin v.rd = 1; v.addr = UADDR; end
          2: begin v.rd = 1; v.wr = 1; v.addr = 32'($urandom_range(0, 127)); end
          default: begin v.wr = 1; v.addr = 32'h0000_4000 + 32'($urandom_range(0, 255)); end
        endcase
      end
      apply(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
